// File: rtl/switch_mcu_regfile_wb.sv
// Write-back register file: arbitrates NUM_WPORTS ALU writes into 2**ADDR_W GPRs (x0 = 0),
// serves two registered read ports with write bypass, and zero-sweeps storage after reset.
module switch_mcu_regfile_wb #(
  parameter int NUM_WPORTS = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic [NUM_WPORTS-1:0]        in_wen,
  input  logic [NUM_WPORTS*ADDR_W-1:0] in_waddr,
  input  logic [NUM_WPORTS*DATA_W-1:0] in_wdata,
  input  logic                         in_ren,
  input  logic [ADDR_W-1:0]            in_raddr1,
  input  logic [ADDR_W-1:0]            in_raddr2,
  input  logic                         in_clr_collide,
  output logic [DATA_W-1:0]            out_rdata1,
  output logic [DATA_W-1:0]            out_rdata2,
  output logic                         out_rvalid,
  output logic                         out_ready,
  output logic                         out_collide
);

  localparam int NUM_REGS = 2**ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_ready;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   r_rdata1;
  logic [DATA_W-1:0]   r_rdata2;
  logic                r_rvalid;
  logic                r_collide;

  logic [ADDR_W-1:0]   w_addr [NUM_WPORTS];
  logic [DATA_W-1:0]   w_data [NUM_WPORTS];
  logic [NUM_WPORTS-1:0] w_win;
  logic                w_collide;
  logic                w_run;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;

  assign w_run = (r_state == ST_RUN);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state <= ST_CLEAR;
      r_ptr   <= ADDR_W'(1);
      r_ready <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ready <= (w_nextState == ST_RUN);
      if (r_state == ST_CLEAR) r_ptr <= r_ptr + 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (r_state == ST_CLEAR && r_ptr == '1) w_nextState = ST_RUN;
  end

  always_comb begin
    for (int p = 0; p < NUM_WPORTS; p++) begin
      w_addr[p] = in_waddr[p*ADDR_W +: ADDR_W];
      w_data[p] = in_wdata[p*DATA_W +: DATA_W];
    end
  end

  // A port wins unless a lower-index port targets the same nonzero address.
  always_comb begin
    w_win     = '0;
    w_collide = 1'b0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      if (w_run && in_wen[p] && w_addr[p] != '0) begin
        w_win[p] = 1'b1;
        for (int q = 0; q < p; q++) begin
          if (in_wen[q] && w_addr[q] == w_addr[p]) begin
            w_win[p]  = 1'b0;
            w_collide = 1'b1;
          end
        end
      end
    end
  end

  // Winners have distinct addresses, so at most one bypass source matches each read port.
  always_comb begin
    w_rd1 = (in_raddr1 == '0) ? '0 : r_regs[in_raddr1];
    w_rd2 = (in_raddr2 == '0) ? '0 : r_regs[in_raddr2];
    for (int p = 0; p < NUM_WPORTS; p++) begin
      if (w_win[p] && w_addr[p] == in_raddr1) w_rd1 = w_data[p];
      if (w_win[p] && w_addr[p] == in_raddr2) w_rd2 = w_data[p];
    end
  end

  // Storage has no reset so it can map to RAM; the sweep provides the zero state.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      if (r_state == ST_CLEAR) begin
        r_regs[r_ptr] <= '0;
      end else begin
        for (int p = 0; p < NUM_WPORTS; p++) begin
          if (w_win[p]) r_regs[w_addr[p]] <= w_data[p];
        end
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_rdata1  <= '0;
      r_rdata2  <= '0;
      r_rvalid  <= 1'b0;
      r_collide <= 1'b0;
    end else begin
      r_rvalid <= in_ren && w_run;
      if (in_ren && w_run) begin
        r_rdata1 <= w_rd1;
        r_rdata2 <= w_rd2;
      end
      if (w_collide)           r_collide <= 1'b1;
      else if (in_clr_collide) r_collide <= 1'b0;
    end
  end

  assign out_rdata1  = r_rdata1;
  assign out_rdata2  = r_rdata2;
  assign out_rvalid  = r_rvalid;
  assign out_ready   = r_ready;
  assign out_collide = r_collide;

endmodule
